// File: rtl/if_async_rx.sv
// rtl/if_async_rx.sv - async four-phase handshake receiver feeding a FWFT valid/ready FIFO.
// Optional stall counter port enabled by IF_ASYNC_RX_STALL_CNT_EN.
module if_async_rx #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       async_en,
  input  logic [DATA_W-1:0]          async_data,
  output logic                       async_rdy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH):0]     fifo_count
`ifdef IF_ASYNC_RX_STALL_CNT_EN
  ,
  output logic [15:0]                stall_cnt
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   en_s;
  state_t                 state_q;
  logic                   rdy_q;

  logic [DATA_W-1:0]      mem_q [DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [AW:0]            count_q, count_d;

  logic                   full;
  logic                   push;
  logic                   pop;

  assign en_s = sync_q[SYNC_STAGES-1];
  assign full = (count_q == FULL_CNT);
  // The full test uses the pre-edge count, so a pop while full never frees room for a push on the same edge.
  assign push = (state_q == IDLE) && en_s && !full;
  assign pop  = (count_q != '0) && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_en};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en_s && !full) begin
            state_q <= ACK;
            rdy_q   <= 1'b1;
          end
        end
        ACK: begin
          if (!en_s) begin
            state_q <= IDLE;
            rdy_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          rdy_q   <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the zeroed count hides stale entries.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= async_data;
    end
  end

`ifdef IF_ASYNC_RX_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if ((state_q == IDLE) && en_s && full && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

  assign async_rdy  = rdy_q;
  assign out_valid  = (count_q != '0);
  assign out_data   = mem_q[rd_ptr_q];
  assign fifo_count = count_q;

endmodule
